traffic_timer_bank: RTL and testbench
=====================================

TRAFFIC_TIMER_BANK -- requirements
Module: traffic_timer_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick; legal range 1 to 2^26.
REQ-003 Parameter T_LONG, default 60: seconds counted by the 60 s timer; legal range 1 to 63.
REQ-004 Parameter T_MID, default 50: seconds counted by the 50 s timer; legal range 1 to 63.
REQ-005 Parameter T_SHORT, default 10: seconds counted by the 10 s timer; legal range 1 to 63.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 timer_en  input  1  count enable; 0 freezes all three timers.
REQ-009 timer_reset_60  input  1  restart request for the T_LONG timer.
REQ-010 timer_reset_50  input  1  restart request for the T_MID timer.
REQ-011 timer_reset_10  input  1  restart request for the T_SHORT timer.
REQ-012 timer_done_60  output  1  registered; T_LONG seconds have elapsed since the last restart.
REQ-013 timer_done_50  output  1  registered; T_MID seconds have elapsed since the last restart.
REQ-014 timer_done_10  output  1  registered; T_SHORT seconds have elapsed since the last restart.

Function
REQ-015 The block SHALL contain three identical, independent timer channels: 60 (T_LONG), 50 (T_MID) and 10 (T_SHORT).
REQ-016 Each channel SHALL hold a sub-second counter (0 to TICK_DIV-1, width clog2(TICK_DIV), minimum 1 bit), a 6-bit seconds counter, and a done register.
REQ-017 Each channel SHALL implement two states, COUNTING and EXPIRED.
REQ-018 A channel's timer_reset sampled high at an edge SHALL clear its sub-second counter, seconds counter and done register, and place the channel in COUNTING. This applies regardless of timer_en and of the current state.
REQ-019 In COUNTING with timer_en=1 and timer_reset=0, the sub-second counter SHALL increment by 1 per edge.
REQ-020 When the sub-second counter equals TICK_DIV-1, it SHALL wrap to 0 and the seconds counter SHALL increment. With TICK_DIV=1, the seconds counter increments every enabled edge.
REQ-021 At the edge where the seconds counter becomes T, done SHALL go high and the channel SHALL enter EXPIRED.
REQ-022 Consequently, done rises exactly T*TICK_DIV enabled edges after the last edge at which timer_reset was sampled high.
REQ-023 In EXPIRED, all counters SHALL hold, and done SHALL stay high until the next timer_reset; no wrap or re-trigger occurs.
REQ-024 If timer_reset is held high for several cycles, counting SHALL start from the last edge at which it was sampled high.
REQ-025 A restart mid-count SHALL discard the elapsed time.
REQ-026 If timer_reset is high at the same edge where expiry would occur, reset SHALL win and done SHALL stay 0.
REQ-027 timer_en=0 SHALL freeze counters and done in every channel; pending restarts still take effect.
REQ-028 A restart of one channel SHALL NOT affect the other channels.
REQ-029 Seconds-counter arithmetic SHALL be unsigned 6-bit and SHALL never exceed T.

Reset
REQ-030 While reset_n=0, every channel SHALL have counters=0, done=0 and state COUNTING; all timer_done outputs SHALL be 0.
REQ-031 After reset_n is released, every channel SHALL begin counting at the first rising edge without any timer_reset, so timer_done_60 rises T_LONG*TICK_DIV edges after release.
REQ-032 Assertion of reset_n mid-count or in EXPIRED SHALL immediately force the reset values of REQ-030, without waiting for a clock edge.

Verification (TICK_DIV=4, defaults otherwise, timer_en=1 unless stated)
REQ-033 Release reset_n, no restarts -> done_10 rises at edge 40, done_50 at edge 200, done_60 at edge 240; all stay high thereafter.
REQ-034 Pulse timer_reset_10 for 1 cycle at edge 100 -> done_10 drops at edge 100 and rises at edge 140; done_50 and done_60 are unaffected.
REQ-035 Hold timer_reset_10 high for edges 0-5, then pulse it again at edge 30 -> done_10 rises at edge 70, not at edge 45.
REQ-036 Drive timer_en=0 for 8 cycles, starting 20 edges after a restart of timer_reset_10 -> done_10 rises 48 edges after the restart.
REQ-037 Assert timer_reset_10 at the edge done_10 would rise (edge 40) -> done_10 stays 0, then rises at edge 80.
REQ-038 Assert reset_n=0 asynchronously at edge 120 plus a half cycle -> all done outputs are 0 immediately, and done_10 rises again 40 edges after release.

Source files
------------

// File: rtl/traffic_timer_bank.sv
// Three independent restartable second-timers (T_LONG, T_MID, T_SHORT) sharing one tick divisor.
// done outputs are registered; a restart wins over a coincident expiry; there is no backpressure.

module traffic_timer_channel #(
  parameter int TICK_DIV = 50000000,
  parameter int T        = 60
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic done
);

  localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICK_DIV - 1);
  localparam logic [5:0]       SEC_T   = 6'(T);

  typedef enum logic {COUNTING, EXPIRED} state_t;

  state_t           state, state_nxt;
  logic [SUB_W-1:0] sub_cnt, sub_cnt_nxt;
  logic [5:0]       sec_cnt, sec_cnt_nxt;
  logic             done_nxt;
  logic [5:0]       sec_inc;

  assign sec_inc = sec_cnt + 6'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= COUNTING;
      sub_cnt <= '0;
      sec_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sub_cnt <= sub_cnt_nxt;
      sec_cnt <= sec_cnt_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sub_cnt_nxt = sub_cnt;
    sec_cnt_nxt = sec_cnt;
    done_nxt    = done;
    if (restart) begin
      // Restart is honoured even while disabled or expired, and beats expiry.
      state_nxt   = COUNTING;
      sub_cnt_nxt = '0;
      sec_cnt_nxt = '0;
      done_nxt    = 1'b0;
    end else if (en && state == COUNTING) begin
      if (sub_cnt == SUB_MAX) begin
        sub_cnt_nxt = '0;
        sec_cnt_nxt = sec_inc;
        if (sec_inc == SEC_T) begin
          done_nxt  = 1'b1;
          state_nxt = EXPIRED;
        end
      end else begin
        sub_cnt_nxt = sub_cnt + SUB_W'(1);
      end
    end
  end

endmodule

module traffic_timer_bank #(
  parameter int TICK_DIV = 50000000,
  parameter int T_LONG   = 60,
  parameter int T_MID    = 50,
  parameter int T_SHORT  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic timer_en,
  input  logic timer_reset_60,
  input  logic timer_reset_50,
  input  logic timer_reset_10,
  output logic timer_done_60,
  output logic timer_done_50,
  output logic timer_done_10
);

  traffic_timer_channel #(.TICK_DIV(TICK_DIV), .T(T_LONG)) u_ch_60 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timer_en),
    .restart (timer_reset_60),
    .done    (timer_done_60)
  );

  traffic_timer_channel #(.TICK_DIV(TICK_DIV), .T(T_MID)) u_ch_50 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timer_en),
    .restart (timer_reset_50),
    .done    (timer_done_50)
  );

  traffic_timer_channel #(.TICK_DIV(TICK_DIV), .T(T_SHORT)) u_ch_10 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timer_en),
    .restart (timer_reset_10),
    .done    (timer_done_10)
  );

endmodule

// File: tb/tb_traffic_timer_bank.sv
// Bench for traffic_timer_bank: per-edge expected done triples from an elapsed-edge model,
// checked by an independent monitor on the falling clock edge.

module tb_traffic_timer_bank;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic timer_en = 1'b0;
  logic timer_reset_60 = 1'b0;
  logic timer_reset_50 = 1'b0;
  logic timer_reset_10 = 1'b0;
  logic timer_done_60, timer_done_50, timer_done_10;

  int checks = 0;
  int failures = 0;

  // Expected {done_60, done_50, done_10} after each rising edge.
  logic [2:0] exp_q[$];

  // Model: enabled edges elapsed since last restart, saturating at the limit.
  int elapsed[3];
  int limit[3];
  int edge_no = 0;

  traffic_timer_bank #(.TICK_DIV(TD), .T_LONG(60), .T_MID(50), .T_SHORT(10)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .timer_en       (timer_en),
    .timer_reset_60 (timer_reset_60),
    .timer_reset_50 (timer_reset_50),
    .timer_reset_10 (timer_reset_10),
    .timer_done_60  (timer_done_60),
    .timer_done_50  (timer_done_50),
    .timer_done_10  (timer_done_10)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model_done();
    logic [2:0] d;
    for (int c = 0; c < 3; c++) d[c] = (elapsed[c] == limit[c]);
    return d;
  endfunction

  // Drive inputs away from the edge, let one rising edge happen, update the model.
  task automatic step(input logic en, input logic r60, input logic r50, input logic r10);
    logic [2:0] r;
    timer_en = en;
    timer_reset_60 = r60;
    timer_reset_50 = r50;
    timer_reset_10 = r10;
    r = {r60, r50, r10};
    @(posedge clk);
    edge_no++;
    for (int c = 0; c < 3; c++) begin
      if (!reset_n || r[c]) elapsed[c] = 0;
      else if (en && elapsed[c] < limit[c]) elapsed[c]++;
    end
    exp_q.push_back(model_done());
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e, a;
      e = exp_q.pop_front();
      a = {timer_done_60, timer_done_50, timer_done_10};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL done_cycle t=%0t actual{60,50,10}=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic async_reset_check();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) elapsed[c] = 0;
    #1;
    checks++;
    if ({timer_done_60, timer_done_50, timer_done_10} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset actual=%b required=000",
               {timer_done_60, timer_done_50, timer_done_10});
    end
  endtask

  initial begin
    limit[0] = 10 * TD;
    limit[1] = 50 * TD;
    limit[2] = 60 * TD;
    for (int c = 0; c < 3; c++) elapsed[c] = 0;

    // Edges while reset is asserted must keep everything at zero.
    @(negedge clk);
    #1;
    run(3, 1'b1);
    reset_n = 1'b1;

    // Free run from release: done_10 at 40, done_50 at 200, done_60 at 240, then hold.
    run(260, 1'b1);

    // Single-cycle restart of the short timer; the others must not move.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run(45, 1'b1);

    // Restart held for six edges, then re-pulsed mid-count.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    run(24, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run(45, 1'b1);

    // Enable dropped for eight cycles partway through the count.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run(20, 1'b1);
    run(8, 1'b0);
    run(25, 1'b1);

    // Restart coincident with the expiry edge, plus a restart while disabled.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run(39, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run(42, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0);
    run(30, 1'b1);

    // Asynchronous reset mid-cycle, a few edges held, then recovery from release.
    async_reset_check();
    run(2, 1'b1);
    reset_n = 1'b1;
    run(45, 1'b1);

    // Randomised mix of enable gaps and per-channel restarts.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 299) == 0,
           $urandom_range(0, 249) == 0,
           $urandom_range(0, 59) == 0);
    end

    // Async reset from a random mid-count point.
    async_reset_check();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    run(300, 1'b1);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
